// File: rtl/alp_seq_arith_unit.sv
// rtl/alp_seq_arith_unit.sv - sequential ADD/SUB/MUL/DIV unit with START/BUSY/DONE handshake
// Define SIGNED_OPS_EN to make SMUL/SDIV legal; otherwise they end with an ERR pulse.
module alp_seq_arith_unit #(
    parameter int W     = 4,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         CLK,
    input  logic         CLR_N,
    input  logic         LOAD,
    input  logic         START,
    input  logic [2:0]   OP,
    input  logic [W-1:0] DIN_A,
    input  logic [W-1:0] DIN_B,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR,
    output logic [W-1:0] RES_HI,
    output logic [W-1:0] RES_LO,
    output logic [3:0]   STAT
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
`ifdef SIGNED_OPS_EN
    localparam logic [2:0] OP_SMUL = 3'b101;
    localparam logic [2:0] OP_SDIV = 3'b110;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     r0_q, r0_d, r1_q, r1_d;
    logic [W-1:0]     acc_q, acc_d, q_q, q_d, b_q, b_d;
    logic             done_q, done_d, err_q, err_d;
    logic [W-1:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [3:0]       stat_q, stat_d;
`ifdef SIGNED_OPS_EN
    logic             neg_q, neg_d, neg_rem_q, neg_rem_d;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction
`endif

    logic [W-1:0] op_a, op_b;
    logic [W-1:0] step_acc, step_q, step_b, nxt_acc, nxt_q;
    logic         step_div;
    logic [W:0]   mul_sum, div_sh, div_diff;
    logic [W:0]   addsub;
    logic         is_sub, add_c, add_v;
    logic [W-1:0] fin_hi, fin_lo;

    // A LOAD on the START edge feeds the new operands straight through.
    assign op_a = LOAD ? DIN_A : r0_q;
    assign op_b = LOAD ? DIN_B : r1_q;

    assign is_sub = (OP == OP_SUB);
    assign addsub = is_sub ? ({1'b0, op_a} - {1'b0, op_b}) : ({1'b0, op_a} + {1'b0, op_b});
    assign add_c  = is_sub ? ~addsub[W] : addsub[W];
    assign add_v  = is_sub ? ((op_a[W-1] != op_b[W-1]) && (addsub[W-1] != op_a[W-1]))
                           : ((op_a[W-1] == op_b[W-1]) && (addsub[W-1] != op_a[W-1]));

    // The START edge already performs the first unsigned iteration from fresh operands.
    always_comb begin
        step_acc = acc_q;
        step_q   = q_q;
        step_b   = b_q;
        step_div = (op_q == OP_DIV);
`ifdef SIGNED_OPS_EN
        if (op_q == OP_SDIV) begin
            step_div = 1'b1;
        end
`endif
        if (state_q == S_IDLE) begin
            step_acc = '0;
            step_div = (OP == OP_DIV);
            step_q   = (OP == OP_DIV) ? op_a : op_b;
            step_b   = (OP == OP_DIV) ? op_b : op_a;
        end
    end

    // Remainder stays below the divisor, so bit W of the difference is the borrow.
    always_comb begin
        mul_sum  = {1'b0, step_acc} + (step_q[0] ? {1'b0, step_b} : {(W + 1){1'b0}});
        div_sh   = {step_acc, step_q[W-1]};
        div_diff = div_sh - {1'b0, step_b};
        if (step_div) begin
            if (div_diff[W]) begin
                nxt_acc = div_sh[W-1:0];
                nxt_q   = {step_q[W-2:0], 1'b0};
            end else begin
                nxt_acc = div_diff[W-1:0];
                nxt_q   = {step_q[W-2:0], 1'b1};
            end
        end else begin
            nxt_acc = mul_sum[W:1];
            nxt_q   = {mul_sum[0], step_q[W-1:1]};
        end
    end

    always_comb begin
        fin_hi = nxt_acc;
        fin_lo = nxt_q;
`ifdef SIGNED_OPS_EN
        if ((op_q == OP_SMUL) && neg_q) begin
            {fin_hi, fin_lo} = -{nxt_acc, nxt_q};
        end
        if (op_q == OP_SDIV) begin
            if (neg_q) begin
                fin_lo = -nxt_q;
            end
            if (neg_rem_q) begin
                fin_hi = -nxt_acc;
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        acc_d    = acc_q;
        q_d      = q_q;
        b_d      = b_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        stat_d   = stat_q;
`ifdef SIGNED_OPS_EN
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
`endif
        if (state_q == S_IDLE) begin
            if (LOAD) begin
                r0_d = DIN_A;
                r1_d = DIN_B;
            end
            if (START) begin
                op_d = OP;
                case (OP)
                    OP_NOP: begin
                        op_d = op_q;
                    end
                    OP_ADD, OP_SUB: begin
                        done_d   = 1'b1;
                        res_hi_d = '0;
                        res_lo_d = addsub[W-1:0];
                        stat_d   = {addsub[W-1], ~|addsub[W-1:0], add_c, add_v};
                    end
                    OP_MUL, OP_DIV: begin
                        if ((OP == OP_DIV) && (op_b == '0)) begin
                            done_d   = 1'b1;
                            err_d    = 1'b1;
                            res_hi_d = op_a;
                            res_lo_d = '1;
                            stat_d   = 4'b1000;
                        end else begin
                            state_d = S_RUN;
                            cnt_d   = CNT_ONE;
                            acc_d   = nxt_acc;
                            q_d     = nxt_q;
                            b_d     = step_b;
                        end
                    end
`ifdef SIGNED_OPS_EN
                    OP_SMUL, OP_SDIV: begin
                        if ((OP == OP_SDIV) && (op_b == '0)) begin
                            done_d   = 1'b1;
                            err_d    = 1'b1;
                            res_hi_d = op_a;
                            res_lo_d = '1;
                            stat_d   = 4'b1000;
                        end else begin
                            state_d   = S_RUN;
                            cnt_d     = '0;
                            acc_d     = '0;
                            q_d       = (OP == OP_SMUL) ? mag(op_b) : mag(op_a);
                            b_d       = (OP == OP_SMUL) ? mag(op_a) : mag(op_b);
                            neg_d     = op_a[W-1] ^ op_b[W-1];
                            neg_rem_d = op_a[W-1];
                        end
                    end
`endif
                    default: begin
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        res_hi_d = '0;
                        res_lo_d = '0;
                        stat_d   = '0;
                    end
                endcase
            end
        end else begin
            acc_d = nxt_acc;
            q_d   = nxt_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                res_hi_d = fin_hi;
                res_lo_d = fin_lo;
                stat_d   = {step_div ? fin_lo[W-1] : fin_hi[W-1], ~|{fin_hi, fin_lo}, 2'b00};
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            r0_q     <= '0;
            r1_q     <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            stat_q   <= '0;
`ifdef SIGNED_OPS_EN
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            b_q      <= b_d;
            done_q   <= done_d;
            err_q    <= err_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            stat_q   <= stat_d;
`ifdef SIGNED_OPS_EN
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign BUSY   = (state_q == S_RUN);
    assign DONE   = done_q;
    assign ERR    = err_q;
    assign RES_HI = res_hi_q;
    assign RES_LO = res_lo_q;
    assign STAT   = stat_q;

endmodule

// File: tb/tb_alp_seq_arith_unit.sv
// tb/tb_alp_seq_arith_unit.sv - directed vector bench for alp_seq_arith_unit (W=4)
module tb_alp_seq_arith_unit;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         CLR_N;
    logic         LOAD;
    logic         START;
    logic [2:0]   OP;
    logic [W-1:0] DIN_A;
    logic [W-1:0] DIN_B;
    logic         BUSY;
    logic         DONE;
    logic         ERR;
    logic [W-1:0] RES_HI;
    logic [W-1:0] RES_LO;
    logic [3:0]   STAT;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [3:0]   stat;
        logic         chk_stat;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    alp_seq_arith_unit #(.W(W)) dut (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .LOAD   (LOAD),
        .START  (START),
        .OP     (OP),
        .DIN_A  (DIN_A),
        .DIN_B  (DIN_B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ERR    (ERR),
        .RES_HI (RES_HI),
        .RES_LO (RES_LO),
        .STAT   (STAT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [3:0] stat,
                                    input logic chk_stat, input logic err, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
        v.stat = stat; v.chk_stat = chk_stat; v.err = err; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Called at a falling edge; returns at the falling edge after the START edge.
    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ld);
        OP    = op;
        DIN_A = a;
        DIN_B = b;
        LOAD  = ld;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        LOAD  = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            if (BUSY === 1'b1) busy_cnt++;
            @(negedge CLK);
            lat++;
        end
        if (DONE !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: DONE never rose within %0d cycles", name, lat);
            lat = -1;
        end
        if (BUSY === 1'b1) busy_cnt++;
    endtask

    initial begin
        int   lat;
        int   busy;
        logic seen;

        CLR_N = 1'b0;
        LOAD  = 1'b0;
        START = 1'b0;
        OP    = 3'b000;
        DIN_A = '0;
        DIN_B = '0;

        add_vec(3'b001, 4'd9,  4'd8,  4'h0, 4'h1, 4'b0011, 1'b1, 1'b0, 1);
        add_vec(3'b010, 4'd5,  4'd5,  4'h0, 4'h0, 4'b0110, 1'b1, 1'b0, 1);
        add_vec(3'b010, 4'd3,  4'd5,  4'h0, 4'hE, 4'b1000, 1'b1, 1'b0, 1);
        add_vec(3'b001, 4'd7,  4'd1,  4'h0, 4'h8, 4'b1001, 1'b1, 1'b0, 1);
        add_vec(3'b011, 4'd13, 4'd11, 4'h8, 4'hF, 4'b1000, 1'b1, 1'b0, 4);
        add_vec(3'b011, 4'd0,  4'd9,  4'h0, 4'h0, 4'b0100, 1'b1, 1'b0, 4);
        add_vec(3'b011, 4'd15, 4'd15, 4'hE, 4'h1, 4'b1000, 1'b1, 1'b0, 4);
        add_vec(3'b100, 4'd13, 4'd4,  4'h1, 4'h3, 4'b0000, 1'b1, 1'b0, 4);
        add_vec(3'b100, 4'd15, 4'd1,  4'h0, 4'hF, 4'b1000, 1'b1, 1'b0, 4);
        add_vec(3'b100, 4'd0,  4'd3,  4'h0, 4'h0, 4'b0100, 1'b1, 1'b0, 4);
        add_vec(3'b100, 4'd13, 4'd0,  4'hD, 4'hF, 4'b0000, 1'b0, 1'b1, 1);
        add_vec(3'b111, 4'd5,  4'd6,  4'h0, 4'h0, 4'b0000, 1'b1, 1'b1, 1);
`ifdef SIGNED_OPS_EN
        add_vec(3'b101, 4'hD,  4'd5,  4'hF, 4'h1, 4'b1000, 1'b1, 1'b0, 5);
        add_vec(3'b110, 4'h9,  4'd2,  4'hF, 4'hD, 4'b1000, 1'b1, 1'b0, 5);
`else
        add_vec(3'b101, 4'hD,  4'd5,  4'h0, 4'h0, 4'b0000, 1'b1, 1'b1, 1);
        add_vec(3'b110, 4'h9,  4'd2,  4'h0, 4'h0, 4'b0000, 1'b1, 1'b1, 1);
`endif

        repeat (2) @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_err",  32'(ERR), 32'd0);
        check("rst_hi",   32'(RES_HI), 32'd0);
        check("rst_lo",   32'(RES_LO), 32'd0);
        check("rst_stat", 32'(STAT), 32'd0);
        CLR_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            wait_done($sformatf("v%0d", i), lat, busy);
            check($sformatf("v%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].lat - 1));
            check($sformatf("v%0d_hi", i),   32'(RES_HI), 32'(vecs[i].hi));
            check($sformatf("v%0d_lo", i),   32'(RES_LO), 32'(vecs[i].lo));
            check($sformatf("v%0d_err", i),  32'(ERR), 32'(vecs[i].err));
            if (vecs[i].chk_stat) begin
                check($sformatf("v%0d_stat", i), 32'(STAT), 32'(vecs[i].stat));
            end
            @(negedge CLK);
            check($sformatf("v%0d_done_clr", i), 32'(DONE), 32'd0);
            check($sformatf("v%0d_err_clr", i),  32'(ERR), 32'd0);
        end

        // NOP START: nothing should happen
        start_op(3'b000, 4'd1, 4'd2, 1'b1);
        seen = 1'b0;
        repeat (5) begin
            if (DONE === 1'b1 || BUSY === 1'b1) seen = 1'b1;
            @(negedge CLK);
        end
        check("nop_no_activity", 32'(seen), 32'd0);

        // START/LOAD while busy are ignored; R0/R1 stay 13/11
        LOAD  = 1'b1;
        DIN_A = 4'd13;
        DIN_B = 4'd11;
        @(negedge CLK);
        LOAD = 1'b0;
        start_op(3'b011, 4'd2, 4'd3, 1'b0);
        OP    = 3'b001;
        DIN_A = 4'd2;
        DIN_B = 4'd3;
        LOAD  = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        LOAD  = 1'b0;
        START = 1'b0;
        wait_done("ign", lat, busy);
        check("ign_lat", 32'(lat), 32'd3);
        check("ign_hi",  32'(RES_HI), 32'h8);
        check("ign_lo",  32'(RES_LO), 32'hF);
        // back-to-back START in the DONE cycle, operands from R0/R1
        start_op(3'b011, 4'd2, 4'd3, 1'b0);
        wait_done("b2b", lat, busy);
        check("b2b_lat", 32'(lat), 32'd4);
        check("b2b_hi",  32'(RES_HI), 32'h8);
        check("b2b_lo",  32'(RES_LO), 32'hF);
        @(negedge CLK);

        // asynchronous reset in the middle of a MUL
        start_op(3'b011, 4'd7, 4'd6, 1'b1);
        @(negedge CLK);
        #2;
        CLR_N = 1'b0;
        #1;
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_done", 32'(DONE), 32'd0);
        check("arst_err",  32'(ERR), 32'd0);
        check("arst_hi",   32'(RES_HI), 32'd0);
        check("arst_lo",   32'(RES_LO), 32'd0);
        check("arst_stat", 32'(STAT), 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (DONE === 1'b1 || BUSY === 1'b1) seen = 1'b1;
        end
        check("arst_no_done", 32'(seen), 32'd0);
        CLR_N = 1'b1;
        @(negedge CLK);
        start_op(3'b011, 4'd3, 4'd3, 1'b1);
        wait_done("post_rst", lat, busy);
        check("post_rst_lat", 32'(lat), 32'd4);
        check("post_rst_hi",  32'(RES_HI), 32'h0);
        check("post_rst_lo",  32'(RES_LO), 32'h9);
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
